// File: rtl/seg_scan_ctrl.sv
// Shared scan sequencer for the Basys3 4-digit 7-segment display.
// Frames are double-buffered and committed only when the scan wraps, so a digit never tears.
module seg_scan_ctrl #(
  parameter int REFRESH_TICKS = 250000,
  parameter int BLINK_TICKS   = 50000000
) (
  input  logic       basys_clk,
  input  logic       reset,
  input  logic [6:0] digit0,
  input  logic [6:0] digit1,
  input  logic [6:0] digit2,
  input  logic [6:0] digit3,
  input  logic [3:0] dp_in,
  input  logic [3:0] digit_en,
  input  logic [3:0] blink_en,
  input  logic       latch,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp,
  output logic [1:0] digit_idx,
  output logic       frame_done
);

  localparam int TW = $clog2(REFRESH_TICKS);
  localparam int BW = $clog2(BLINK_TICKS);
  localparam logic [TW-1:0] TICK_LAST  = TW'(REFRESH_TICKS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

  typedef struct packed {
    logic [3:0][6:0] pat;
    logic [3:0]      dp;
    logic [3:0]      en;
    logic [3:0]      blink;
  } frame_t;

  // Power-up/reset frame: every digit disabled, segments dark.
  localparam frame_t BLANK_FRAME = {{4{7'h7F}}, 12'h000};

  logic [TW-1:0] tick_cnt;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;
  logic          pending_valid;
  frame_t        pend_frame;
  frame_t        act_frame;
  frame_t        in_frame;
  logic          tick_last;
  logic          blink_last;
  logic          wrap;
  logic          blank;

  assign in_frame   = {digit3, digit2, digit1, digit0, dp_in, digit_en, blink_en};
  assign tick_last  = (tick_cnt == TICK_LAST);
  assign blink_last = (blink_cnt == BLINK_LAST);
  assign wrap       = tick_last && (digit_idx == 2'd3);
  assign frame_done = wrap && !reset;
  assign blank      = !act_frame.en[digit_idx] ||
                      (act_frame.blink[digit_idx] && blink_phase);

  always_ff @(posedge basys_clk) begin
    if (reset) begin
      tick_cnt      <= '0;
      blink_cnt     <= '0;
      blink_phase   <= 1'b0;
      digit_idx     <= 2'd0;
      pending_valid <= 1'b0;
      pend_frame    <= BLANK_FRAME;
      act_frame     <= BLANK_FRAME;
      seg           <= 7'h7F;
      an            <= 4'hF;
      dp            <= 1'b1;
    end else begin
      tick_cnt <= tick_last ? '0 : tick_cnt + 1'b1;
      if (tick_last) digit_idx <= digit_idx + 2'd1;

      blink_cnt <= blink_last ? '0 : blink_cnt + 1'b1;
      if (blink_last) blink_phase <= !blink_phase;

      // A latch landing on the wrap cycle goes straight to the active frame.
      if (wrap) begin
        if (latch) act_frame <= in_frame;
        else if (pending_valid) act_frame <= pend_frame;
        pending_valid <= 1'b0;
      end else if (latch) begin
        pend_frame    <= in_frame;
        pending_valid <= 1'b1;
      end

      if (blank) begin
        an  <= 4'hF;
        seg <= 7'h7F;
        dp  <= 1'b1;
      end else begin
        an  <= ~(4'b0001 << digit_idx);
        seg <= act_frame.pat[digit_idx];
        dp  <= !act_frame.dp[digit_idx];
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized and directed bench for seg_scan_ctrl against a cycle-count reference model.
module tb_seg_scan_ctrl;

  localparam int R = 4;
  localparam int B = 64;
  localparam int FRAME = 4 * R;

  // clock/reset block
  logic basys_clk = 1'b0;
  always #5 basys_clk = ~basys_clk;

  logic       reset = 1'b1;
  logic [6:0] digit0 = 7'h7F, digit1 = 7'h7F, digit2 = 7'h7F, digit3 = 7'h7F;
  logic [3:0] dp_in = 4'h0, digit_en = 4'h0, blink_en = 4'h0;
  logic       latch = 1'b0;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;
  logic [1:0] digit_idx;
  logic       frame_done;

  seg_scan_ctrl #(.REFRESH_TICKS(R), .BLINK_TICKS(B)) dut (
    .basys_clk (basys_clk),
    .reset     (reset),
    .digit0    (digit0),
    .digit1    (digit1),
    .digit2    (digit2),
    .digit3    (digit3),
    .dp_in     (dp_in),
    .digit_en  (digit_en),
    .blink_en  (blink_en),
    .latch     (latch),
    .seg       (seg),
    .an        (an),
    .dp        (dp),
    .digit_idx (digit_idx),
    .frame_done(frame_done)
  );

  // reference model: n_cyc = clock edges since reset released
  int         n_cyc = 0;
  logic [6:0] act_pat[4];
  logic [3:0] act_dp, act_en, act_bl;
  logic [6:0] pen_pat[4];
  logic [3:0] pen_dp, pen_en, pen_bl;
  logic       pen_valid;
  logic [14:0] exp_q[$];

  int checks_total  = 0;
  int checks_passed = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Predict the effect of the coming clock edge and queue the expected outputs.
  task automatic model_edge();
    logic [6:0] e_seg;
    logic [3:0] e_an;
    logic       e_dp;
    logic [6:0] in_pat[4];
    int         i;
    bit         ph, is_blank, wrap;
    in_pat[0] = digit0; in_pat[1] = digit1; in_pat[2] = digit2; in_pat[3] = digit3;
    if (reset) begin
      e_seg = 7'h7F; e_an = 4'hF; e_dp = 1'b1;
      n_cyc = 0;
      for (int k = 0; k < 4; k++) act_pat[k] = 7'h7F;
      act_dp = '0; act_en = '0; act_bl = '0;
      pen_valid = 1'b0;
    end else begin
      i        = (n_cyc / R) % 4;
      ph       = ((n_cyc / B) % 2) == 1;
      is_blank = !act_en[i] || (act_bl[i] && ph);
      if (is_blank) begin
        e_seg = 7'h7F; e_an = 4'hF; e_dp = 1'b1;
      end else begin
        e_seg = act_pat[i];
        e_an  = 4'hF;
        e_an[i] = 1'b0;
        e_dp  = !act_dp[i];
      end
      wrap = (n_cyc % FRAME) == FRAME - 1;
      if (wrap && latch) begin
        for (int k = 0; k < 4; k++) act_pat[k] = in_pat[k];
        act_dp = dp_in; act_en = digit_en; act_bl = blink_en;
        pen_valid = 1'b0;
      end else if (wrap) begin
        if (pen_valid) begin
          for (int k = 0; k < 4; k++) act_pat[k] = pen_pat[k];
          act_dp = pen_dp; act_en = pen_en; act_bl = pen_bl;
        end
        pen_valid = 1'b0;
      end else if (latch) begin
        for (int k = 0; k < 4; k++) pen_pat[k] = in_pat[k];
        pen_dp = dp_in; pen_en = digit_en; pen_bl = blink_en;
        pen_valid = 1'b1;
      end
      n_cyc++;
    end
    exp_q.push_back({e_seg, e_an, e_dp, 2'((n_cyc / R) % 4),
                     (!reset && (n_cyc % FRAME) == FRAME - 1)});
  endtask

  // driver tasks
  task automatic step();
    logic [14:0] e;
    model_edge();
    @(posedge basys_clk);
    #1;
    e = exp_q.pop_front();
    check_eq("seg", 32'(seg), 32'(e[14:8]));
    check_eq("an", 32'(an), 32'(e[7:4]));
    check_eq("dp", 32'(dp), 32'(e[3]));
    check_eq("digit_idx", 32'(digit_idx), 32'(e[2:1]));
    check_eq("frame_done", 32'(frame_done), 32'(e[0]));
  endtask

  task automatic idle(input int cycles);
    for (int k = 0; k < cycles; k++) step();
  endtask

  task automatic set_frame(input logic [6:0] d0, input logic [6:0] d1, input logic [6:0] d2,
                           input logic [6:0] d3, input logic [3:0] dpv, input logic [3:0] en,
                           input logic [3:0] bl);
    digit0 = d0; digit1 = d1; digit2 = d2; digit3 = d3;
    dp_in = dpv; digit_en = en; blink_en = bl;
  endtask

  task automatic pulse_latch();
    latch = 1'b1;
    step();
    latch = 1'b0;
  endtask

  task automatic run_to_wrap_cycle();
    while ((n_cyc % FRAME) != FRAME - 1) step();
  endtask

  initial begin
    // reset held three cycles, then an idle display
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    idle(40);

    // mid-frame latch, committed at the next wrap
    set_frame(7'h24, 7'h79, 7'h7F, 7'h7F, 4'b0001, 4'b0011, 4'b0000);
    pulse_latch();
    idle(40);

    // two latches within one frame: the later one wins
    run_to_wrap_cycle();
    step();
    set_frame(7'h40, 7'h79, 7'h7F, 7'h7F, 4'b0000, 4'b0011, 4'b0000);
    pulse_latch();
    idle(2);
    set_frame(7'h12, 7'h79, 7'h7F, 7'h7F, 4'b0000, 4'b0011, 4'b0000);
    pulse_latch();
    idle(36);

    // latch on the wrap cycle bypasses the pending buffer
    run_to_wrap_cycle();
    set_frame(7'h30, 7'h06, 7'h5B, 7'h4F, 4'b1010, 4'hF, 4'b0000);
    pulse_latch();
    idle(40);

    // blink on digit 0 only
    set_frame(7'h01, 7'h02, 7'h04, 7'h08, 4'b0101, 4'hF, 4'b0001);
    pulse_latch();
    idle(300);

    // reset drops a latched-but-uncommitted frame
    run_to_wrap_cycle();
    idle(5);
    set_frame(7'h00, 7'h00, 7'h00, 7'h00, 4'hF, 4'hF, 4'h0);
    pulse_latch();
    reset = 1'b1;
    step();
    reset = 1'b0;
    idle(40);

    // randomized traffic with occasional resets
    for (int c = 0; c < 2000; c++) begin
      reset = ($urandom_range(0, 249) == 0);
      latch = ($urandom_range(0, 7) == 0);
      set_frame(7'($urandom), 7'($urandom), 7'($urandom), 7'($urandom),
                4'($urandom), 4'($urandom), 4'($urandom));
      step();
    end
    reset = 1'b0;
    latch = 1'b0;
    idle(20);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for the Basys3 4-digit 7-segment display. It replaces the ad-hoc per-task an/seg/dp state counters with one shared sequencer. Tasks submit a 4-digit frame (segment patterns, decimal points, enables, blink mask) through a latch strobe. The block double-buffers the frame, commits it only at frame boundaries so digits never tear, and drives the active-low seg/an/dp pins.

Parameters:
REFRESH_TICKS, 250000, basys_clk cycles each digit is driven (2.5 ms at 100 MHz); must be >= 2
BLINK_TICKS, 50000000, basys_clk cycles per blink half-period (0.5 s); must be >= 2

Ports:
basys_clk  input  1  system clock, 100 MHz
reset  input  1  synchronous, active-high reset
digit0  input  7  segment pattern for an[0], active-low (bit0 = segment a)
digit1  input  7  segment pattern for an[1]
digit2  input  7  segment pattern for an[2]
digit3  input  7  segment pattern for an[3]
dp_in  input  4  decimal point per digit, 1 = lit
digit_en  input  4  per-digit enable, 0 = digit blanked
blink_en  input  4  per-digit blink enable
latch  input  1  one-cycle strobe that captures all frame inputs
seg  output  7  segment pins, active-low
an  output  4  anode pins, active-low, one-hot-low when driving
dp  output  1  decimal point pin, active-low
digit_idx  output  2  digit currently being scanned
frame_done  output  1  one-cycle pulse when the scan wraps from digit 3 to digit 0

Behaviour:
- Reset (synchronous, active-high, dominates all other inputs):
  - Outputs: seg=7'h7F, an=4'hF, dp=1, digit_idx=0, frame_done=0.
  - Internal state: tick and blink counters = 0, blink_phase = 0, pending_valid = 0.
  - Active frame = all digits disabled, patterns 7'h7F, dp 0, blink 0.
- Tick counter: counts 0..REFRESH_TICKS-1. On terminal count it returns to 0 and digit_idx increments mod 4. digit_idx 0 -> 1 -> 2 -> 3 -> 0.
- Wrap event: the cycle in which the terminal count occurs with digit_idx=3.
  - frame_done pulses high for exactly that cycle.
  - The pending frame commits to the active frame in that cycle.
- Frame buffering:
  - latch=1 captures digit0..3, dp_in, digit_en and blink_en into the pending frame and sets pending_valid. Any pending frame not yet committed is overwritten.
  - At a wrap event with pending_valid=1, pending is copied to active and pending_valid clears.
  - latch on the wrap cycle itself: the inputs sampled that cycle are written directly to active (bypass) and pending_valid clears. No one-frame delay.
- Blink counter: free-running 0..BLINK_TICKS-1. blink_phase toggles on terminal count. It is independent of scanning and not reset by latch.
- Output stage: registered, one cycle after digit_idx/active-frame state. For i = digit_idx:
  - Blank condition: active digit_en[i]=0, or (active blink_en[i]=1 and blink_phase=1).
  - Blanked digit: an=4'hF, seg=7'h7F, dp=1.
  - Otherwise: an = all ones except bit i = 0; seg = active pattern i; dp = ~active dp[i].
  - Only one anode is ever low; an is never driven with more than one zero.
- Mid-operation reset clears the display within the same clock edge. A frame latched before the reset is discarded.
- Widths: counters sized to ceil(log2(param)). No arithmetic outside the counters.

Test Plan:
1. Params REFRESH_TICKS=4, BLINK_TICKS=64. Assert reset 3 cycles, release -> an=4'hF and seg=7'h7F until a latch; digit_idx steps 0,1,2,3,0 every 4 cycles; frame_done high exactly once per 16 cycles (when digit_idx wraps 3->0).
2. Latch digit0=7'h24, digit1=7'h79, digit_en=4'b0011, dp_in=4'b0001 mid-frame -> outputs unchanged until the next frame_done. Afterwards: an=4'b1110/seg=7'h24/dp=0 while digit_idx=0; an=4'b1101/seg=7'h79/dp=1 while digit_idx=1; an=4'hF while digit_idx=2 or 3.
3. Two latches in one frame (digit0=7'h40 then 7'h12) -> only 7'h12 appears after the commit.
4. Latch asserted on the wrap cycle with digit0=7'h30 -> 7'h30 is driven on the very next digit-0 slot; pending_valid=0 afterwards.
5. blink_en=4'b0001, digit_en=4'hF -> digit 0 is blanked (an=4'hF during its slot) for 64 cycles, then shown for 64 cycles, repeating; digits 1-3 are never blanked.
6. Reset asserted mid-frame with a latched-but-uncommitted frame -> seg/an/dp return to 7'h7F/4'hF/1 the next cycle; the display stays blank after release with no new latch.
